// File: rtl/bus_arbiter_pkg.sv
// Shared 9444 bus arbiter types: grant encoding, FSM states, watchdog sizing and the tie-break rule.
package bus_arbiter_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

  typedef enum logic [1:0] {
    GRANT__NONE = 2'd0,
    GRANT__M0   = 2'd1,
    GRANT__M1   = 2'd2
  } grant_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  // A zero limit disables the watchdog, but the counter still needs a legal width.
  function automatic int unsigned watchdog_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

  function automatic grant_t arbitrate(input logic req0, input logic req1, input logic prefer_m0);
    if (req0 && (!req1 || prefer_m0)) return GRANT__M0;
    if (req1) return GRANT__M1;
    return GRANT__NONE;
  endfunction

endpackage

// File: rtl/execute.sv
// Execute-stage types shared with the memory system: XLEN and the access-kind/size encoding.
package execute;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    MEM_NONE   = 4'd0,
    BYTE_READ  = 4'd1,
    HALF_READ  = 4'd2,
    WORD_READ  = 4'd3,
    BYTE_WRITE = 4'd4,
    HALF_WRITE = 4'd5,
    WORD_WRITE = 4'd6
  } memory_access_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// One 9444 bus port. The requester side uses the master modport; the responder side uses the slave modport.
interface bus_arbiter_if;
  import execute::*;

  logic                  cycle;
  logic [31:0]           paddr;
  memory_access_t        access;
  logic [XLEN-1:0]       data_out;
  logic [4*XLEN-1:0]     data_in;
  logic                  ack;

  modport master (
    output cycle, paddr, access, data_out,
    input  data_in, ack
  );

  modport slave (
    input  cycle, paddr, access, data_out,
    output data_in, ack
  );

endinterface

// File: rtl/bus_arbiter_watchdog.sv
// Saturating count of owned cycles without a slave ack plus a sticky timeout flag (TIMEOUT_CYCLES = 0 disables).
module bus_arbiter_watchdog
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic done,
  output logic timeout
);

  localparam int unsigned CNT_W = watchdog_width(TIMEOUT_CYCLES);

  if (TIMEOUT_CYCLES == 0) begin : g_disabled
    assign timeout = 1'b0;
  end else begin : g_enabled
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;
    logic             flag;
    logic             hit;

    // The cycle that brings the count to the limit already reports the timeout.
    assign hit = active && !done && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
      if (reset) begin
        count <= '0;
        flag  <= 1'b0;
      end else begin
        if (!active || done) begin
          count <= '0;
        end else if (count != LIMIT) begin
          count <= count + CNT_W'(1);
        end
        if (hit) begin
          flag <= 1'b1;
        end
      end
    end

    assign timeout = flag | (hit & ~reset);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the 9444 memory bus; ownership is locked from grant until the slave ack.
// Build option BUS_ARBITER_FIXED_PRIORITY_EN: m1 wins every tie; otherwise ties alternate round-robin.
module bus_arbiter
  import bus_arbiter_pkg::*;
  import execute::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  bus_arbiter_if.slave  m0,
  bus_arbiter_if.slave  m1,
  bus_arbiter_if.master s,
  output grant_t        grant,
  output logic          timeout
);

  state_t state;
  grant_t pick;
  logic   own0;
  logic   own1;
  logic   prefer_m0;

  assign own0 = (state == ST_OWN0);
  assign own1 = (state == ST_OWN1);

`ifdef BUS_ARBITER_FIXED_PRIORITY_EN
  assign prefer_m0 = 1'b0;
`else
  grant_t last_grant;

  assign prefer_m0 = (last_grant == GRANT__M1);

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= GRANT__M1;
    end else if ((state == ST_IDLE) && (pick != GRANT__NONE)) begin
      last_grant <= pick;
    end
  end
`endif

  assign pick = arbitrate(m0.cycle, m1.cycle, prefer_m0);

  // Arbitration only happens in IDLE, so the ack cycle never re-grants the still-high requester.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      grant <= GRANT__NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          grant <= pick;
          case (pick)
            GRANT__M0: state <= ST_OWN0;
            GRANT__M1: state <= ST_OWN1;
            default:   state <= ST_IDLE;
          endcase
        end
        ST_OWN0, ST_OWN1: begin
          if (s.ack) begin
            state <= ST_IDLE;
            grant <= GRANT__NONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= GRANT__NONE;
        end
      endcase
    end
  end

  assign s.cycle    = (own0 & m0.cycle) | (own1 & m1.cycle);
  assign s.paddr    = own0 ? m0.paddr    : (own1 ? m1.paddr    : '0);
  assign s.access   = own0 ? m0.access   : (own1 ? m1.access   : MEM_NONE);
  assign s.data_out = own0 ? m0.data_out : (own1 ? m1.data_out : '0);

  assign m0.ack     = own0 & s.ack;
  assign m1.ack     = own1 & s.ack;
  assign m0.data_in = s.data_in;
  assign m1.data_in = s.data_in;

  bus_arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .active (state != ST_IDLE),
    .done   (s.ack),
    .timeout(timeout)
  );

`ifndef SYNTHESIS
  // A master must hold its request until acked; ownership is kept regardless.
  m0_holds_cycle: assert property (@(posedge clock) disable iff (reset) own0 |-> m0.cycle)
    else $error("bus_arbiter: m0 dropped its cycle before ack");
  m1_holds_cycle: assert property (@(posedge clock) disable iff (reset) own1 |-> m1.cycle)
    else $error("bus_arbiter: m1 dropped its cycle before ack");
`endif

endmodule
